// File: rtl/dtcm_resp_pkg.sv
// rtl/dtcm_resp_pkg.sv - shared types and helpers for the DTCM responder (parity helper used with DTCM_PARITY_EN)
package dtcm_resp_pkg;

  localparam int XLEN    = 32;
  localparam int DTCM_AW = 12;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  // Even parity per byte: each bit makes its byte plus itself have an even count of ones.
  function automatic logic [XLEN/8-1:0] byte_parity(input logic [XLEN-1:0] word);
    logic [XLEN/8-1:0] par;
    par = '0;
    for (int b = 0; b < XLEN / 8; b++) begin
      par[b] = ^word[b*8 +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/dtcm_sram.sv
// rtl/dtcm_sram.sv - 2^AW x WW synchronous array, one write port, one registered read port
module dtcm_sram #(
  parameter int AW = 12,
  parameter int WW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] mem [0:(1<<AW)-1];
  logic [WW-1:0] rdata_q;

  // Storage is never reset; the read register only updates on an enabled read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dtcm_resp.sv
// rtl/dtcm_resp.sv - DTCM responder: posted-write buffer, forwarding, range check; DTCM_PARITY_EN adds byte parity
module dtcm_resp
  import dtcm_resp_pkg::*;
#(
  parameter int AW = DTCM_AW,
  parameter int DW = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_i_wr,
  input  logic            lsu_i_rd,
  input  logic [31:0]     lsu_i_addr,
  input  logic [DW-1:0]   lsu_i_wdata,
`ifdef DTCM_PARITY_EN
  input  logic [DW/8-1:0] ram_i_par_inject,
`endif
  output logic [DW-1:0]   ram_o_rdata,
  output logic            ram_o_rvalid,
  output logic            ram_o_err,
  output logic            ram_o_wbuf_busy
);

`ifdef DTCM_PARITY_EN
  localparam int SW = DW + DW / 8;
`else
  localparam int SW = DW;
`endif

  wb_state_e     state_q, state_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          rvalid_q, rvalid_d;
  logic          oor_q, oor_d;
  logic          fwd_q, fwd_d;
  logic [DW-1:0] fwd_data_q, fwd_data_d;
  logic          err_range_q, err_range_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          in_range;
  logic          wr_ok;
  logic          rd_acc;
  logic          commit;
  logic          sram_re;
  logic [SW-1:0] sram_wdata;
  logic [SW-1:0] sram_rdata;
  logic [DW-1:0] rdata_mux;
  logic          par_err;

  // Request decode: buffer next state, forwarding decision and response staging.
  always_comb begin
    in_range    = (lsu_i_addr[31:AW] == '0);
    wr_ok       = lsu_i_wr && in_range;
    rd_acc      = lsu_i_rd && !lsu_i_wr;
    // A full buffer drains every cycle, whether or not a new write replaces it.
    commit      = (state_q == WB_FULL);
    state_d     = wr_ok ? WB_FULL : WB_EMPTY;
    wb_addr_d   = wr_ok ? lsu_i_addr[AW-1:0] : wb_addr_q;
    wb_data_d   = wr_ok ? lsu_i_wdata : wb_data_q;
    rvalid_d    = rd_acc;
    oor_d       = rd_acc && !in_range;
    fwd_d       = rd_acc && in_range && (state_q == WB_FULL) &&
                  (wb_addr_q == lsu_i_addr[AW-1:0]);
    fwd_data_d  = fwd_d ? wb_data_q : fwd_data_q;
    err_range_d = (lsu_i_wr && !in_range) || oor_d;
    sram_re     = rd_acc && in_range && !fwd_d;
`ifdef DTCM_PARITY_EN
    sram_wdata  = {byte_parity(wb_data_q) ^ ram_i_par_inject, wb_data_q};
`else
    sram_wdata  = wb_data_q;
`endif
  end

  // Response mux: out-of-range reads return zero, forwarded reads return buffered data.
  always_comb begin
    rdata_mux = sram_rdata[DW-1:0];
    if (oor_q) begin
      rdata_mux = '0;
    end else if (fwd_q) begin
      rdata_mux = fwd_data_q;
    end
    hold_d  = rvalid_q ? rdata_mux : hold_q;
`ifdef DTCM_PARITY_EN
    par_err = rvalid_q && !oor_q && !fwd_q &&
              (|(byte_parity(sram_rdata[DW-1:0]) ^ sram_rdata[SW-1:DW]));
`else
    par_err = 1'b0;
`endif
    ram_o_rdata     = rvalid_q ? rdata_mux : hold_q;
    ram_o_rvalid    = rvalid_q;
    ram_o_err       = err_range_q || par_err;
    ram_o_wbuf_busy = (state_q == WB_FULL);
  end

  // State and response registers; reset drops any pending buffered write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WB_EMPTY;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      rvalid_q    <= 1'b0;
      oor_q       <= 1'b0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
      err_range_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      rvalid_q    <= rvalid_d;
      oor_q       <= oor_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
      err_range_q <= err_range_d;
      hold_q      <= hold_d;
    end
  end

  dtcm_sram #(
    .AW (AW),
    .WW (SW)
  ) u_sram (
    .clk   (clk),
    .we    (commit),
    .waddr (wb_addr_q),
    .wdata (sram_wdata),
    .re    (sram_re),
    .raddr (lsu_i_addr[AW-1:0]),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_dtcm_resp.sv
// tb/tb_dtcm_resp.sv - directed self-checking bench for dtcm_resp (parity case with DTCM_PARITY_EN)
module tb_dtcm_resp;

  logic        clk;
  logic        rst;
  logic        lsu_i_wr;
  logic        lsu_i_rd;
  logic [31:0] lsu_i_addr;
  logic [31:0] lsu_i_wdata;
  logic [3:0]  ram_i_par_inject;
  logic [31:0] ram_o_rdata;
  logic        ram_o_rvalid;
  logic        ram_o_err;
  logic        ram_o_wbuf_busy;

  int total;
  int bad;

  dtcm_resp dut (
    .clk             (clk),
    .rst             (rst),
    .lsu_i_wr        (lsu_i_wr),
    .lsu_i_rd        (lsu_i_rd),
    .lsu_i_addr      (lsu_i_addr),
    .lsu_i_wdata     (lsu_i_wdata),
`ifdef DTCM_PARITY_EN
    .ram_i_par_inject(ram_i_par_inject),
`endif
    .ram_o_rdata     (ram_o_rdata),
    .ram_o_rvalid    (ram_o_rvalid),
    .ram_o_err       (ram_o_err),
    .ram_o_wbuf_busy (ram_o_wbuf_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [31:0] data);
    lsu_i_wr    = wr;
    lsu_i_rd    = rd;
    lsu_i_addr  = addr;
    lsu_i_wdata = data;
    @(posedge clk);
    #1;
    lsu_i_wr = 1'b0;
    lsu_i_rd = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    lsu_i_wr = 1'b0;
    lsu_i_rd = 1'b0;
    lsu_i_addr = '0;
    lsu_i_wdata = '0;
    ram_i_par_inject = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", ram_o_rdata, 32'h0);
    chk("rst_rvalid", {31'b0, ram_o_rvalid}, 32'h0);
    chk("rst_err", {31'b0, ram_o_err}, 32'h0);
    chk("rst_busy", {31'b0, ram_o_wbuf_busy}, 32'h0);
    rst = 1'b0;

    // Write, drain, then read from the array.
    cyc(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("w10_busy", {31'b0, ram_o_wbuf_busy}, 32'h1);
    chk("w10_norv", {31'b0, ram_o_rvalid}, 32'h0);
    idle();
    chk("w10_drain", {31'b0, ram_o_wbuf_busy}, 32'h0);
    cyc(1'b0, 1'b1, 32'h10, 32'h0);
    chk("r10_rvalid", {31'b0, ram_o_rvalid}, 32'h1);
    chk("r10_rdata", ram_o_rdata, 32'hDEADBEEF);
    chk("r10_err", {31'b0, ram_o_err}, 32'h0);
    idle();
    chk("r10_idle_rv", {31'b0, ram_o_rvalid}, 32'h0);
    chk("r10_hold", ram_o_rdata, 32'hDEADBEEF);

    // Read-after-write forwarding.
    cyc(1'b1, 1'b0, 32'h20, 32'h12345678);
    chk("w20_busy", {31'b0, ram_o_wbuf_busy}, 32'h1);
    cyc(1'b0, 1'b1, 32'h20, 32'h0);
    chk("r20_rvalid", {31'b0, ram_o_rvalid}, 32'h1);
    chk("r20_fwd", ram_o_rdata, 32'h12345678);
    chk("r20_busy_after", {31'b0, ram_o_wbuf_busy}, 32'h0);

    // Back-to-back writes, one idle, then a held read across both words.
    cyc(1'b1, 1'b0, 32'h30, 32'hA);
    cyc(1'b1, 1'b0, 32'h31, 32'hB);
    chk("w31_busy", {31'b0, ram_o_wbuf_busy}, 32'h1);
    idle();
    chk("w31_drain", {31'b0, ram_o_wbuf_busy}, 32'h0);
    lsu_i_rd = 1'b1;
    lsu_i_addr = 32'h30;
    @(posedge clk);
    #1;
    chk("r30_rvalid", {31'b0, ram_o_rvalid}, 32'h1);
    chk("r30_rdata", ram_o_rdata, 32'hA);
    lsu_i_addr = 32'h31;
    @(posedge clk);
    #1;
    chk("r31_rvalid", {31'b0, ram_o_rvalid}, 32'h1);
    chk("r31_rdata", ram_o_rdata, 32'hB);
    lsu_i_rd = 1'b0;

    // Simultaneous read and write: write wins, read ignored.
    cyc(1'b1, 1'b1, 32'h40, 32'h00C0FFEE);
    chk("rw40_norv", {31'b0, ram_o_rvalid}, 32'h0);
    chk("rw40_busy", {31'b0, ram_o_wbuf_busy}, 32'h1);
    idle();
    cyc(1'b0, 1'b1, 32'h40, 32'h0);
    chk("r40_rvalid", {31'b0, ram_o_rvalid}, 32'h1);
    chk("r40_rdata", ram_o_rdata, 32'h00C0FFEE);

    // Out-of-range read and write; the write must not alias onto word 0.
    cyc(1'b1, 1'b0, 32'h0, 32'h11111111);
    idle();
    cyc(1'b0, 1'b1, 32'h1000, 32'h0);
    chk("roor_rvalid", {31'b0, ram_o_rvalid}, 32'h1);
    chk("roor_rdata", ram_o_rdata, 32'h0);
    chk("roor_err", {31'b0, ram_o_err}, 32'h1);
    cyc(1'b1, 1'b0, 32'h1000, 32'h99);
    chk("woor_err", {31'b0, ram_o_err}, 32'h1);
    chk("woor_norv", {31'b0, ram_o_rvalid}, 32'h0);
    chk("woor_nobusy", {31'b0, ram_o_wbuf_busy}, 32'h0);
    idle();
    chk("woor_err_end", {31'b0, ram_o_err}, 32'h0);
    cyc(1'b0, 1'b1, 32'h0, 32'h0);
    chk("r0_unchanged", ram_o_rdata, 32'h11111111);
    chk("r0_err", {31'b0, ram_o_err}, 32'h0);

    // Reset with a pending write: the buffered word is lost.
    cyc(1'b1, 1'b0, 32'h50, 32'h77);
    idle();
    cyc(1'b1, 1'b0, 32'h50, 32'h55);
    chk("w50_busy", {31'b0, ram_o_wbuf_busy}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rdata", ram_o_rdata, 32'h0);
    chk("arst_busy", {31'b0, ram_o_wbuf_busy}, 32'h0);
    chk("arst_rvalid", {31'b0, ram_o_rvalid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b1, 32'h50, 32'h0);
    chk("r50_old", ram_o_rdata, 32'h77);
    chk("r50_rvalid", {31'b0, ram_o_rvalid}, 32'h1);

`ifdef DTCM_PARITY_EN
    // Corrupt stored parity at commit; a clean word still reads without error.
    cyc(1'b1, 1'b0, 32'h60, 32'h1234);
    ram_i_par_inject = 4'h1;
    idle();
    ram_i_par_inject = 4'h0;
    cyc(1'b0, 1'b1, 32'h60, 32'h0);
    chk("par_err", {31'b0, ram_o_err}, 32'h1);
    chk("par_raw", ram_o_rdata, 32'h1234);
    cyc(1'b0, 1'b1, 32'h50, 32'h0);
    chk("par_clean", {31'b0, ram_o_err}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
